mult_div_unit: RTL

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the same register-file operands as the ALU (A = rs, B = rt) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The MFHI/MFLO writeback mux reads hi/lo directly.
- Control stalls the PC while busy is high.

---
 rtl/md_pkg.sv | 30 +++
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared types, encodings and sign fix-up helpers for the multiply/divide unit.
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle through a
// shared 64-bit shift register and a single adder/subtractor.
module mult_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import md_pkg::*;

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  md_state_e         state_r, state_nx;
  logic [5:0]        cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opnd_r;
  logic              neg_q_r, neg_r_r;
  logic [XLEN-1:0]   hi_r, lo_r;
  logic              busy_r, done_r, dbz_r;

  logic              accept_s, is_signed_s, div_zero_s, last_s, sub_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN:0]     op_a_s, op_b_s;
  logic [XLEN+1:0]   sum_s;
  logic [2*XLEN-1:0] acc_nx_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

  // Operand conditioning and start qualification.
  always_comb begin
    accept_s    = start & ~busy_r;
    is_signed_s = (md_op == MD_MULT) || (md_op == MD_DIV);
    div_zero_s  = md_op[1] && (B == {XLEN{1'b0}});
    a_mag_s     = is_signed_s ? abs32(A) : A;
    b_mag_s     = is_signed_s ? abs32(B) : B;
    last_s      = (cnt_r == LAST_CNT);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (div_zero_s) state_nx = DONE;
          else            state_nx = md_op[1] ? DIV : MUL;
        end else begin
          state_nx = IDLE;
        end
      end
      MUL:     state_nx = last_s ? DONE : MUL;
      DIV:     state_nx = last_s ? DONE : DIV;
      default: state_nx = IDLE;
    endcase
  end

  // Shared adder: add for shift-add multiply, trial subtract for restoring divide.
  always_comb begin
    sub_s  = (state_r == DIV);
    op_b_s = {1'b0, opnd_r};
    if (sub_s) op_a_s = acc_r[2*XLEN-1:XLEN-1];
    else       op_a_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
    sum_s = {1'b0, op_a_s} + ({1'b0, op_b_s} ^ {(XLEN+2){sub_s}})
          + {{(XLEN+1){1'b0}}, sub_s};
  end

  // One iteration step plus sign fix-up of the completed result.
  always_comb begin
    if (sub_s) begin
      // A clear top bit means no borrow: the divisor fits, so shift in a 1.
      if (sum_s[XLEN+1]) acc_nx_s = {acc_r[2*XLEN-2:0], 1'b0};
      else               acc_nx_s = {sum_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      if (acc_r[0]) acc_nx_s = {sum_s[XLEN:0], acc_r[XLEN-1:1]};
      else          acc_nx_s = {1'b0, acc_r[2*XLEN-1:1]};
    end
    prod_s = neg_q_r ? neg64(acc_nx_s) : acc_nx_s;
    quo_s  = neg_q_r ? neg32(acc_nx_s[XLEN-1:0]) : acc_nx_s[XLEN-1:0];
    rem_s  = neg_r_r ? neg32(acc_nx_s[2*XLEN-1:XLEN]) : acc_nx_s[2*XLEN-1:XLEN];
  end

  // State, status flags, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      cnt_r   <= 6'd0;
      acc_r   <= {(2*XLEN){1'b0}};
      opnd_r  <= {XLEN{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      hi_r    <= {XLEN{1'b0}};
      lo_r    <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx == MUL) || (state_nx == DIV);
      done_r  <= (state_nx == DONE);
      if (accept_s) begin
        cnt_r   <= 6'd0;
        dbz_r   <= div_zero_s;
        neg_q_r <= is_signed_s & (A[XLEN-1] ^ B[XLEN-1]);
        neg_r_r <= is_signed_s & md_op[1] & A[XLEN-1];
        if (md_op[1]) begin
          acc_r  <= {{XLEN{1'b0}}, a_mag_s};
          opnd_r <= b_mag_s;
        end else begin
          acc_r  <= {{XLEN{1'b0}}, b_mag_s};
          opnd_r <= a_mag_s;
        end
        if (div_zero_s) begin
          hi_r <= A;
          lo_r <= {XLEN{1'b1}};
        end
      end else if (busy_r) begin
        cnt_r <= cnt_r + 6'd1;
        acc_r <= acc_nx_s;
        if (last_s) begin
          if (state_r == MUL) begin
            hi_r <= prod_s[2*XLEN-1:XLEN];
            lo_r <= prod_s[XLEN-1:0];
          end else begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end
        end
      end else begin
        if (mthi) hi_r <= A;
        if (mtlo) lo_r <= A;
      end
    end
  end

endmodule
